// File: rtl/memwb_load_reg_pkg.sv
// Shared types and constants for the MEM/WB load path.
//   - funct3 load-type codes
//   - ld_state_t : load FSM state (IDLE, WAIT)
//   - load_ctx_t : load context captured when a load enters the stage
package memwb_load_reg_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } ld_state_t;

    typedef struct packed {
        logic [2:0] funct3;
        logic [1:0] offset;
        logic [4:0] rd;
        logic       regwrite;
        logic       memtoreg;
    } load_ctx_t;

endpackage

// File: rtl/memwb_load_reg_load_align.sv
// load_align: selects the addressed byte/halfword from a word-aligned read
// word and sign- or zero-extends it according to funct3.
// Ports:
//   rdata  in  32  word-aligned read data
//   funct3 in  3   load type (unknown codes behave as LW)
//   offset in  2   byte offset of the load address
//   result out 32  extended load result
// Misaligned offsets are masked (off[0] for halfwords, off[1:0] for words).
module load_align
    import memwb_load_reg_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (offset)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase

        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   result = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  result = {24'd0, byte_sel};
            F3_LHU:  result = {16'd0, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/memwb_load_reg.sv
// memwb_load_reg: MEM/WB stage register on the load side of the data memory.
// Non-load instructions are registered straight into WB. A load stalls the
// pipeline until DM_rvalid (or a timeout after MAX_WAIT cycles in WAIT), then
// writes the aligned, extended read data into WB.
// Ports:
//   clk, reset        clock (rising edge), synchronous active-high reset
//   MEM_*             MEM-stage instruction fields (held upstream while stalled)
//   DM_rdata/rvalid   data-memory read response
//   load_stall        combinational stall for IF..MEM
//   load_timeout      sticky: a load completed by timeout (cleared by reset)
//   WB_*              registered write-back payload
//   debug_state       current FSM state
//   debug_ctx         captured load context
//
// Handshake: a load is accepted in IDLE when MEM_MemRead=1; the memory's
// response is a single-cycle DM_rvalid pulse that is consumed in WAIT and
// ignored in IDLE. load_stall low means upstream may advance at the next edge.
module memwb_load_reg
    import memwb_load_reg_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] MEM_ALU_out,
    input  logic [XLEN-1:0] MEM_pc,
    input  logic [4:0]      MEM_write_addr,
    input  logic [2:0]      MEM_funct3,
    input  logic            MEM_RDSrc,
    input  logic            MEM_MemtoReg,
    input  logic            MEM_MemRead,
    input  logic            MEM_RegWrite,
    input  logic [XLEN-1:0] DM_rdata,
    input  logic            DM_rvalid,
    output logic            load_stall,
    output logic            load_timeout,
    output logic [4:0]      WB_write_addr,
    output logic            WB_RegWrite,
    output logic [XLEN-1:0] WB_write_data,
    output ld_state_t       debug_state,
    output load_ctx_t       debug_ctx
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_WAIT - 1);

    ld_state_t       state;
    logic [CW-1:0]   wait_cnt;
    load_ctx_t       ctx;
    logic [XLEN-1:0] aligned;

    load_align u_align (
        .rdata  (DM_rdata),
        .funct3 (ctx.funct3),
        .offset (ctx.offset),
        .result (aligned)
    );

    // In WAIT the last counter value lets upstream go: that cycle the load
    // completes either with data or by timeout.
    always_comb begin
        load_stall = 1'b0;
        if (!reset) begin
            case (state)
                IDLE:    load_stall = MEM_MemRead;
                WAIT:    load_stall = ~DM_rvalid & (wait_cnt != LAST_CNT);
                default: load_stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            ctx           <= '0;
            WB_write_addr <= '0;
            WB_RegWrite   <= 1'b0;
            WB_write_data <= '0;
            load_timeout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (MEM_MemRead) begin
                        ctx.funct3   <= MEM_funct3;
                        ctx.offset   <= MEM_ALU_out[1:0];
                        ctx.rd       <= MEM_write_addr;
                        ctx.regwrite <= MEM_RegWrite;
                        ctx.memtoreg <= MEM_MemtoReg;
                        wait_cnt     <= '0;
                        WB_RegWrite  <= 1'b0;
                        state        <= WAIT;
                    end else begin
                        WB_write_addr <= MEM_write_addr;
                        WB_RegWrite   <= MEM_RegWrite;
                        WB_write_data <= MEM_RDSrc ? MEM_pc : MEM_ALU_out;
                    end
                end
                WAIT: begin
                    // Data written regardless of captured MemtoReg: MemRead dominates.
                    if (DM_rvalid) begin
                        WB_write_data <= aligned;
                        WB_write_addr <= ctx.rd;
                        WB_RegWrite   <= ctx.regwrite;
                        state         <= IDLE;
                    end else if (wait_cnt == LAST_CNT) begin
                        WB_write_data <= '0;
                        WB_write_addr <= ctx.rd;
                        WB_RegWrite   <= ctx.regwrite;
                        load_timeout  <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign debug_state = state;
    assign debug_ctx   = ctx;

endmodule
